// File: rtl/zigbee_sym_fifo.sv
// Parametrised synchronous symbol FIFO with level/threshold flags, flush and sticky error flags.
// Define ZIGBEE_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module zigbee_sym_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2
) (
    input  logic                         inClock,
    input  logic                         inReset,
    input  logic [DATA_WIDTH-1:0]        inData,
    input  logic                         inWriteEnable,
    input  logic                         inReadEnable,
    input  logic                         inFlush,
    input  logic                         inClearErr,
    output logic [DATA_WIDTH-1:0]        outData,
    output logic                         outValid,
    output logic                         outFull,
    output logic                         outEmpty,
    output logic                         outAlmostFull,
    output logic                         outAlmostEmpty,
    output logic [$clog2(DEPTH+1)-1:0]   outCount,
    output logic                         outOverflow,
    output logic                         outUnderflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] FULL_LEVEL   = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_LEVEL     = CNT_WIDTH'(DEPTH - AF_MARGIN);
    localparam logic [CNT_WIDTH-1:0] AE_LEVEL     = CNT_WIDTH'(AE_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wrPtr;
    logic [PTR_WIDTH-1:0]  rdPtr;
    logic [CNT_WIDTH-1:0]  count;

    logic isFull;
    logic isEmpty;
    logic readAccept;
    logic writeAccept;
    logic overflowEvent;
    logic underflowEvent;

    assign isFull  = (count == FULL_LEVEL);
    assign isEmpty = (count == '0);

    // A flush swallows both requests, so neither side can be accepted or flag an error.
    always_comb begin
        readAccept     = inReadEnable && !isEmpty && !inFlush;
        writeAccept    = inWriteEnable && (!isFull || readAccept) && !inFlush;
        overflowEvent  = inWriteEnable && !writeAccept && !inFlush;
        underflowEvent = inReadEnable && isEmpty && !inFlush;
    end

    always_ff @(posedge inClock) begin
        if (!inReset && writeAccept) begin
            mem[wrPtr] <= inData;
        end
    end

    always_ff @(posedge inClock) begin
        if (inReset || inFlush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (writeAccept) begin
                wrPtr <= wrPtr + PTR_WIDTH'(1);
            end
            if (readAccept) begin
                rdPtr <= rdPtr + PTR_WIDTH'(1);
            end
            case ({writeAccept, readAccept})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error event wins over a coincident clear so no event is ever lost.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            outOverflow  <= 1'b0;
            outUnderflow <= 1'b0;
        end else begin
            outOverflow  <= (outOverflow && !inClearErr) || overflowEvent;
            outUnderflow <= (outUnderflow && !inClearErr) || underflowEvent;
        end
    end

`ifdef ZIGBEE_FIFO_FWFT_EN
    assign outData  = mem[rdPtr];
    assign outValid = !isEmpty;
`else
    always_ff @(posedge inClock) begin
        if (inReset) begin
            outData  <= '0;
            outValid <= 1'b0;
        end else if (inFlush) begin
            outValid <= 1'b0;
        end else begin
            outValid <= readAccept;
            if (readAccept) begin
                outData <= mem[rdPtr];
            end
        end
    end
`endif

    assign outFull        = isFull;
    assign outEmpty       = isEmpty;
    assign outAlmostFull  = (count >= AF_LEVEL);
    assign outAlmostEmpty = (count <= AE_LEVEL);
    assign outCount       = count;

endmodule
